// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and widths for the instruction/data memory port arbiter.
package mem_port_arbiter_pkg;

  localparam int ADDR_W = 30;
  localparam int DATA_W = 32;
  localparam int BE_W   = DATA_W / 8;

  typedef enum logic [1:0] {IDLE, BUS, RESP} arb_state_t;
  typedef enum logic {OWN_I, OWN_D} owner_t;

  // True when a word address falls inside the decoded memory window.
  function automatic logic addr_ok(input logic [ADDR_W-1:0] addr, input int unsigned words);
    return 64'(addr) < 64'(words);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-bus signals of the arbiter, grouped with master (arbiter) and slave (environment) views.
interface mem_port_arbiter_if;
  import mem_port_arbiter_pkg::*;

  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_ack;
  logic [DATA_W-1:0] i_rdata;
  logic              i_err;

  logic              d_req;
  logic [ADDR_W-1:0] d_addr;
  logic              d_we;
  logic [BE_W-1:0]   d_be;
  logic [DATA_W-1:0] d_wd;
  logic              d_inhibit;
  logic              d_ack;
  logic [DATA_W-1:0] d_rdata;
  logic              d_err;

  logic              m_req;
  logic [ADDR_W-1:0] m_addr;
  logic              m_we;
  logic [BE_W-1:0]   m_be;
  logic [DATA_W-1:0] m_wd;
  logic              m_rdy;
  logic [DATA_W-1:0] m_rdata;

  logic              busy;

  modport master (
    input  i_req, i_addr,
    output i_ack, i_rdata, i_err,
    input  d_req, d_addr, d_we, d_be, d_wd, d_inhibit,
    output d_ack, d_rdata, d_err,
    output m_req, m_addr, m_we, m_be, m_wd,
    input  m_rdy, m_rdata,
    output busy
  );

  modport slave (
    output i_req, i_addr,
    input  i_ack, i_rdata, i_err,
    output d_req, d_addr, d_we, d_be, d_wd, d_inhibit,
    input  d_ack, d_rdata, d_err,
    input  m_req, m_addr, m_we, m_be, m_wd,
    output m_rdy, m_rdata,
    input  busy
  );

endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory bus between ifetch and data ports; data has priority
// but ifetch is guaranteed a grant after D_MAX back-to-back data grants.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int MEM_WORDS = 65536,
  parameter int TIMEOUT   = 255,
  parameter int D_MAX     = 4
) (
  input logic                clk,
  input logic                reset_n,
  mem_port_arbiter_if.master bus
);

  localparam int TCNT_W = 10;
  localparam int DCNT_W = 4;

  arb_state_t        state_q, state_d;
  owner_t            owner_q, owner_d;
  logic [DCNT_W-1:0] dcnt_q, dcnt_d;
  logic [TCNT_W-1:0] tcnt_q, tcnt_d;
  logic              m_req_q, m_req_d;
  logic [ADDR_W-1:0] m_addr_q, m_addr_d;
  logic              m_we_q, m_we_d;
  logic [BE_W-1:0]   m_be_q, m_be_d;
  logic [DATA_W-1:0] m_wd_q, m_wd_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              err_q, err_d;

  logic              grant_d;
  logic [ADDR_W-1:0] win_addr;
  logic              resp_load;
  logic [DATA_W-1:0] resp_data;

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    dcnt_d    = dcnt_q;
    tcnt_d    = tcnt_q;
    m_req_d   = m_req_q;
    m_addr_d  = m_addr_q;
    m_we_d    = m_we_q;
    m_be_d    = m_be_q;
    m_wd_d    = m_wd_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    err_d     = err_q;
    resp_load = 1'b0;
    resp_data = '0;

    grant_d  = bus.d_req && (!bus.i_req || dcnt_q != DCNT_W'(D_MAX));
    win_addr = grant_d ? bus.d_addr : bus.i_addr;

    case (state_q)
      IDLE: begin
        if (bus.i_req || bus.d_req) begin
          owner_d  = grant_d ? OWN_D : OWN_I;
          m_addr_d = win_addr;
          m_we_d   = grant_d && bus.d_we;
          m_be_d   = grant_d ? bus.d_be : '1;
          m_wd_d   = grant_d ? bus.d_wd : '0;
          dcnt_d   = (grant_d && bus.i_req) ? dcnt_q + DCNT_W'(1) : '0;
          // Out-of-range and inhibited writes answer without touching the bus.
          if (!addr_ok(win_addr, MEM_WORDS)) begin
            state_d   = RESP;
            err_d     = 1'b1;
            resp_load = 1'b1;
          end else if (grant_d && bus.d_we && bus.d_inhibit) begin
            state_d   = RESP;
            err_d     = 1'b0;
            resp_load = 1'b1;
          end else begin
            state_d = BUS;
            m_req_d = 1'b1;
            tcnt_d  = '0;
          end
        end
      end

      BUS: begin
        if (bus.m_rdy) begin
          state_d   = RESP;
          m_req_d   = 1'b0;
          err_d     = 1'b0;
          resp_load = 1'b1;
          resp_data = m_we_q ? '0 : bus.m_rdata;
        end else if (tcnt_q == TCNT_W'(TIMEOUT - 1)) begin
          state_d   = RESP;
          m_req_d   = 1'b0;
          err_d     = 1'b1;
          resp_load = 1'b1;
        end else begin
          tcnt_d = tcnt_q + TCNT_W'(1);
        end
      end

      RESP: begin
        state_d = IDLE;
        m_req_d = 1'b0;
      end

      default: begin
        state_d = IDLE;
        m_req_d = 1'b0;
      end
    endcase

    // Each port keeps its last read data; only the transaction owner's copy updates.
    if (resp_load) begin
      if (owner_d == OWN_D) d_rdata_d = resp_data;
      else                  i_rdata_d = resp_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      owner_q   <= OWN_I;
      dcnt_q    <= '0;
      tcnt_q    <= '0;
      m_req_q   <= 1'b0;
      m_addr_q  <= '0;
      m_we_q    <= 1'b0;
      m_be_q    <= '0;
      m_wd_q    <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      dcnt_q    <= dcnt_d;
      tcnt_q    <= tcnt_d;
      m_req_q   <= m_req_d;
      m_addr_q  <= m_addr_d;
      m_we_q    <= m_we_d;
      m_be_q    <= m_be_d;
      m_wd_q    <= m_wd_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
      err_q     <= err_d;
    end
  end

  assign bus.i_ack   = (state_q == RESP) && (owner_q == OWN_I);
  assign bus.d_ack   = (state_q == RESP) && (owner_q == OWN_D);
  assign bus.i_err   = bus.i_ack && err_q;
  assign bus.d_err   = bus.d_ack && err_q;
  assign bus.i_rdata = i_rdata_q;
  assign bus.d_rdata = d_rdata_q;
  assign bus.m_req   = m_req_q;
  assign bus.m_addr  = m_addr_q;
  assign bus.m_we    = m_we_q;
  assign bus.m_be    = m_be_q;
  assign bus.m_wd    = m_wd_q;
  assign bus.busy    = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed requests push expected responses,
// a negedge monitor pops and compares on every ACK.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int MEM_WORDS_TB = 65536;
  localparam int TIMEOUT_TB   = 8;
  localparam int D_MAX_TB     = 4;

  typedef struct packed {
    logic        is_d;
    logic        err;
    logic        chk_rdata;
    logic [31:0] rdata;
  } exp_t;

  logic clk;
  logic reset_n;
  mem_port_arbiter_if bus();

  mem_port_arbiter #(
    .MEM_WORDS(MEM_WORDS_TB),
    .TIMEOUT  (TIMEOUT_TB),
    .D_MAX    (D_MAX_TB)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus.master)
  );

  always #5 clk = ~clk;

  exp_t sb[$];
  int   tests_run = 0;
  int   fails     = 0;

  int          rdy_delay = 0;
  bit          never_rdy = 0;
  bit          force_rdy = 0;
  bit          echo      = 0;
  logic [31:0] mem_data  = '0;
  int          req_run      = 0;
  int          m_req_cycles = 0;
  logic [29:0] last_m_addr  = '0;
  logic        last_m_we    = 1'b0;
  logic [3:0]  last_m_be    = '0;
  logic [31:0] last_m_wd    = '0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests_run++;
    if (act !== expv) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, expv);
    end
  endtask

  // Memory model: answers after rdy_delay cycles of M_REQ, or never when never_rdy is set.
  always @(negedge clk) begin
    if (bus.m_req) begin
      req_run++;
      m_req_cycles++;
      last_m_addr = bus.m_addr;
      last_m_we   = bus.m_we;
      last_m_be   = bus.m_be;
      last_m_wd   = bus.m_wd;
    end else begin
      req_run = 0;
    end
    bus.m_rdy   = force_rdy || (bus.m_req && !never_rdy && req_run > rdy_delay);
    bus.m_rdata = echo ? ({2'b00, bus.m_addr} ^ 32'hC0DE_0000) : mem_data;
  end

  always @(negedge clk) begin
    exp_t e;
    if (reset_n && (bus.i_ack || bus.d_ack)) begin
      if (sb.size() == 0) begin
        tests_run++;
        fails++;
        $display("[TB] FAIL unexpected_ack: got i_ack=%0b d_ack=%0b, expected no ack", bus.i_ack, bus.d_ack);
      end else begin
        e = sb.pop_front();
        checkOutput("ack_port", {30'b0, bus.d_ack, bus.i_ack}, e.is_d ? 32'd2 : 32'd1);
        checkOutput("ack_err", {31'b0, e.is_d ? bus.d_err : bus.i_err}, {31'b0, e.err});
        if (e.chk_rdata)
          checkOutput("ack_rdata", e.is_d ? bus.d_rdata : bus.i_rdata, e.rdata);
      end
    end
  end

  task automatic applyStimulus(input logic is_d, input logic [29:0] addr, input logic we,
                               input logic [3:0] be, input logic [31:0] wd, input logic inhibit,
                               input logic exp_err, input logic chk_rdata, input logic [31:0] exp_rdata,
                               output int lat, output int mreq_n);
    int  start;
    bit  got;
    sb.push_back(exp_t'{is_d, exp_err, chk_rdata, exp_rdata});
    @(posedge clk);
    #1;
    start = m_req_cycles;
    if (is_d) begin
      bus.d_addr = addr; bus.d_we = we; bus.d_be = be; bus.d_wd = wd; bus.d_inhibit = inhibit;
      bus.d_req = 1'b1;
    end else begin
      bus.i_addr = addr;
      bus.i_req  = 1'b1;
    end
    lat = 0;
    got = 0;
    while (!got && lat < 60) begin
      @(negedge clk);
      lat++;
      got = is_d ? bus.d_ack : bus.i_ack;
    end
    bus.i_req = 1'b0;
    bus.d_req = 1'b0;
    if (!got) begin
      tests_run++;
      fails++;
      $display("[TB] FAIL ack_timeout: got no ack in %0d cycles, expected an ack", lat);
    end
    mreq_n = m_req_cycles - start;
  endtask

  initial begin
    int lat, n, acks, w;
    clk = 0;
    reset_n = 0;
    bus.i_req = 0; bus.i_addr = '0;
    bus.d_req = 0; bus.d_addr = '0; bus.d_we = 0; bus.d_be = '0; bus.d_wd = '0; bus.d_inhibit = 0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_m_req",   {31'b0, bus.m_req}, 0);
    checkOutput("rst_m_we",    {31'b0, bus.m_we}, 0);
    checkOutput("rst_busy",    {31'b0, bus.busy}, 0);
    checkOutput("rst_acks",    {30'b0, bus.i_ack, bus.d_ack}, 0);
    checkOutput("rst_errs",    {30'b0, bus.i_err, bus.d_err}, 0);
    checkOutput("rst_m_addr",  {2'b0, bus.m_addr}, 0);
    checkOutput("rst_m_be",    {28'b0, bus.m_be}, 0);
    checkOutput("rst_m_wd",    bus.m_wd, 0);
    checkOutput("rst_i_rdata", bus.i_rdata, 0);
    checkOutput("rst_d_rdata", bus.d_rdata, 0);
    reset_n = 1;

    // Single ifetch with a two-cycle bus wait.
    rdy_delay = 2; mem_data = 32'hDEAD_BEEF;
    applyStimulus(0, 30'h100, 0, 4'hF, '0, 0, 0, 1, 32'hDEAD_BEEF, lat, n);
    checkOutput("if_mreq_cycles", n, 3);
    checkOutput("if_latency", lat, 5);
    checkOutput("if_m_addr", {2'b0, last_m_addr}, 32'h100);

    // Both ports held: expect D,D,D,D,I,D,D,D,D,I.
    rdy_delay = 0; echo = 1;
    for (int k = 0; k < 10; k++) begin
      if (k == 4 || k == 9) sb.push_back(exp_t'{1'b0, 1'b0, 1'b1, 32'hC0DE_0040});
      else                  sb.push_back(exp_t'{1'b1, 1'b0, 1'b1, 32'hC0DE_0080});
    end
    @(posedge clk);
    #1;
    bus.i_addr = 30'h40;
    bus.d_addr = 30'h80; bus.d_we = 0; bus.d_be = 4'hF; bus.d_inhibit = 0;
    bus.i_req = 1; bus.d_req = 1;
    acks = 0;
    w = 0;
    while (acks < 10 && w < 100) begin
      @(negedge clk);
      w++;
      if (bus.i_ack || bus.d_ack) acks++;
    end
    bus.i_req = 0; bus.d_req = 0;
    echo = 0;
    checkOutput("arb_ack_count", acks, 10);
    repeat (2) @(negedge clk);
    checkOutput("arb_sb_drained", sb.size(), 0);

    // Out-of-range read short-circuits; last in-range word goes to the bus.
    mem_data = 32'h0BAD_F00D;
    applyStimulus(1, 30'(MEM_WORDS_TB), 0, 4'hF, '0, 0, 1, 1, 32'h0, lat, n);
    checkOutput("oor_mreq_cycles", n, 0);
    checkOutput("oor_latency", lat, 2);
    applyStimulus(1, 30'(MEM_WORDS_TB - 1), 0, 4'hF, '0, 0, 0, 1, 32'h0BAD_F00D, lat, n);
    checkOutput("edge_mreq_cycles", n, 1);
    checkOutput("edge_latency", lat, 3);
    checkOutput("edge_m_addr", {2'b0, last_m_addr}, 32'(MEM_WORDS_TB - 1));

    // Bus timeout.
    never_rdy = 1;
    applyStimulus(1, 30'h30, 0, 4'hF, '0, 0, 1, 1, 32'h0, lat, n);
    checkOutput("to_mreq_cycles", n, TIMEOUT_TB);
    checkOutput("to_latency", lat, TIMEOUT_TB + 2);
    checkOutput("to_busy_at_ack", {31'b0, bus.busy}, 1);
    @(negedge clk);
    checkOutput("to_busy_after", {31'b0, bus.busy}, 0);
    never_rdy = 0;

    // Inhibited write is dropped; the same write without inhibit reaches the bus.
    applyStimulus(1, 30'h20, 1, 4'b0011, 32'h1234_5678, 1, 0, 0, 32'h0, lat, n);
    checkOutput("inh_mreq_cycles", n, 0);
    checkOutput("inh_latency", lat, 2);
    applyStimulus(1, 30'h20, 1, 4'b0011, 32'h1234_5678, 0, 0, 1, 32'h0, lat, n);
    checkOutput("wr_mreq_cycles", n, 1);
    checkOutput("wr_m_we", {31'b0, last_m_we}, 1);
    checkOutput("wr_m_be", {28'b0, last_m_be}, 32'h3);
    checkOutput("wr_m_wd", last_m_wd, 32'h1234_5678);

    // Reset while the bus cycle is outstanding.
    never_rdy = 1;
    @(posedge clk);
    #1;
    bus.d_addr = 30'h44; bus.d_we = 0; bus.d_inhibit = 0; bus.d_req = 1;
    w = 0;
    while (!bus.m_req && w < 20) begin
      @(negedge clk);
      w++;
    end
    checkOutput("rst_mid_reached_bus", {31'b0, bus.m_req}, 1);
    @(negedge clk);
    reset_n = 0;
    bus.d_req = 0;
    @(negedge clk);
    checkOutput("rst_mid_m_req", {31'b0, bus.m_req}, 0);
    checkOutput("rst_mid_busy", {31'b0, bus.busy}, 0);
    reset_n = 1;
    never_rdy = 0;
    force_rdy = 1;
    acks = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.i_ack || bus.d_ack) acks++;
    end
    force_rdy = 0;
    checkOutput("rst_mid_no_ack", acks, 0);
    checkOutput("rst_mid_stray_busy", {31'b0, bus.busy}, 0);
    rdy_delay = 1; mem_data = 32'hCAFE_F00D;
    applyStimulus(0, 30'h200, 0, 4'hF, '0, 0, 0, 1, 32'hCAFE_F00D, lat, n);
    checkOutput("post_rst_mreq_cycles", n, 2);
    checkOutput("post_rst_latency", lat, 4);

    repeat (3) @(negedge clk);
    checkOutput("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port memory bus between the instruction-fetch port and the data port of the pipeline.
- Arbitrates between the two ports, sequences each bus transaction with a ready handshake and returns read data per requester.
- Generates IBE/DBE-style error responses for out-of-range addresses and bus timeouts.
- Sits between the datapath memory interface and the memory/peripheral fabric.

Parameters:
MEM_WORDS, 65536, number of 32-bit words decoded; word address >= MEM_WORDS is an error.
TIMEOUT, 255, max cycles M_REQ may wait for M_RDY before aborting with error (1..1023).
D_MAX, 4, max consecutive data grants while an ifetch is pending (1..15).

Ports:
CLK  in  1  clock
RESET_N  in  1  synchronous, active-low reset
I_REQ  in  1  ifetch request, held with I_ADDR until I_ACK
I_ADDR  in  30  ifetch word address
I_ACK  out  1  one-cycle ifetch completion pulse
I_RDATA  out  32  ifetch data, valid with I_ACK
I_ERR  out  1  ifetch bus error, valid with I_ACK
D_REQ  in  1  data request, held with D_* until D_ACK
D_ADDR  in  30  data word address
D_WE  in  1  1 = write, 0 = read
D_BE  in  4  byte enables
D_WD  in  32  write data
D_INHIBIT  in  1  suppress the write (exception in flight)
D_ACK  out  1  one-cycle data completion pulse
D_RDATA  out  32  load data, valid with D_ACK
D_ERR  out  1  data bus error, valid with D_ACK
M_REQ  out  1  bus request
M_ADDR  out  30  bus word address
M_WE  out  1  bus write
M_BE  out  4  bus byte enables
M_WD  out  32  bus write data
M_RDY  in  1  bus completes the transaction this cycle
M_RDATA  in  32  bus read data, valid with M_RDY
BUSY  out  1  FSM not in IDLE

Behaviour:
- Interface: one clock CLK; reset RESET_N synchronous, active-low.
- Reset (RESET_N=0 at a rising edge): state IDLE. M_REQ, M_WE, I_ACK, D_ACK, I_ERR, D_ERR, BUSY = 0. M_ADDR, M_BE, M_WD, I_RDATA, D_RDATA = 0. Grant counter and timeout counter = 0.
- Reset mid-transaction aborts immediately: M_REQ drops the next cycle and no ACK is issued. The bus must tolerate the abandoned cycle.
- FSM states: IDLE, BUS, RESP.
- IDLE, no request: stay in IDLE.
- IDLE, request present: pick the winner and register the winner's fields into M_* and the owner flag.
  - Only one REQ: that port wins.
  - Both REQ: data wins unless dcnt == D_MAX, in which case ifetch wins.
- IDLE, dcnt update:
  - dcnt increments on a data grant while I_REQ=1.
  - dcnt clears on any ifetch grant.
  - dcnt clears when I_REQ=0 at arbitration.
- IDLE, short-circuit cases (go to RESP without a bus cycle):
  - Address >= MEM_WORDS: ERR=1, RDATA=0.
  - Data write with D_INHIBIT=1: ERR=0, write dropped.
- IDLE, all other requests go to BUS with M_REQ=1 and timeout counter = 0.
- BUS: M_* held stable.
  - M_RDY=1: capture M_RDATA (writes capture 0), go to RESP with ERR=0.
  - Else, counter == TIMEOUT-1: M_REQ drops, go to RESP with ERR=1, RDATA=0.
  - Else, counter increments.
- RESP: the owner's ACK=1 for exactly one cycle, with RDATA/ERR valid. M_REQ=0. The other port's ACK stays 0. Next state IDLE.
- Outside RESP: RDATA holds its last value; ERR and ACK = 0.
- Minimum latency: REQ sampled at edge 0 → M_REQ high in cycle 1 → M_RDY in cycle 1 → ACK in cycle 2 → next arbitration at the edge ending cycle 3. Throughput is one access per 3 cycles.
- Requesters may change REQ/fields at the edge after their ACK. The arbiter ignores REQ outside IDLE.
- M_RDY while not in BUS is ignored.
- D_INHIBIT is sampled only at arbitration. Once a write is on the bus it completes.
- BUSY = (state != IDLE).

Decomposition:
- Shared cpu package holds:
  - arb_state_t enum {IDLE, BUS, RESP}.
  - owner_t enum {OWN_I, OWN_D}.
  - Widths ADDR_W=30 and DATA_W=32.
- Single flat module; no sub-module. Timeout and starvation counters are inline.

Test Plan:
- I_REQ only, I_ADDR=0x100, M_RDY after 2 cycles with M_RDATA=0xDEADBEEF → M_REQ high 3 cycles, single I_ACK with I_RDATA=0xDEADBEEF, I_ERR=0.
- I_REQ and D_REQ held continuously, D_MAX=4, M_RDY=1 always → grant order D,D,D,D,I,D,D,D,D,I; each ACK pulses once per grant.
- D write to D_ADDR=0x20, D_BE=4'b0011, D_WD=0x12345678, D_INHIBIT=1 → M_REQ never asserts; D_ACK=1, D_ERR=0 two cycles after request.
- D read, D_ADDR=MEM_WORDS → no bus cycle; D_ACK with D_ERR=1, D_RDATA=0. Repeat with address MEM_WORDS-1 → normal bus cycle.
- D read with M_RDY held 0, TIMEOUT=8 → M_REQ high exactly 8 cycles, then D_ACK with D_ERR=1; BUSY falls the cycle after.
- RESET_N=0 for one cycle while in BUS → M_REQ=0, BUSY=0 next cycle, no ACK; a later M_RDY is ignored, and a new I_REQ is served normally.
